// File: rtl/game_pkg.sv
// Shared types and constants for the cat/dog/chicken match sequencer:
// choice encodings, FSM states, screen indices and result codes.
package game_pkg;

    typedef enum logic [2:0] {
        CAT     = 3'b001,
        DOG     = 3'b010,
        CHICKEN = 3'b100
    } choice_t;

    typedef enum logic [3:0] {
        ST_TITLE,
        ST_WAIT_START,
        ST_PROMPT,
        ST_WAIT_CHOICE,
        ST_RESOLVE,
        ST_SHOW,
        ST_CHECK,
        ST_WAIT_CONT,
        ST_FINAL,
        ST_OVER
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10
    } result_t;

    localparam logic [6:0] SCR_TITLE      = 7'd0;
    localparam logic [6:0] SCR_PROMPT     = 7'd1;
    localparam logic [6:0] SCR_MATCH_BASE = 7'd2;
    localparam logic [6:0] SCR_P1WIN      = 7'd11;
    localparam logic [6:0] SCR_P2WIN      = 7'd12;

    // Anything that is not a clean one-hot code falls back to cat.
    function automatic choice_t decode_choice(input logic [2:0] raw);
        case (raw)
            3'b010:  return DOG;
            3'b100:  return CHICKEN;
            default: return CAT;
        endcase
    endfunction

    function automatic logic [1:0] choice_idx(input choice_t c);
        case (c)
            DOG:     return 2'd1;
            CHICKEN: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic result_t judge(input choice_t c1, input choice_t c2);
        if (c1 == c2)
            return RES_NONE;
        if ((c1 == DOG && c2 == CAT) || (c1 == CAT && c2 == CHICKEN) ||
            (c1 == CHICKEN && c2 == DOG))
            return RES_P1;
        return RES_P2;
    endfunction

    function automatic logic [6:0] matchup_screen(input choice_t c1, input choice_t c2);
        return 7'(SCR_MATCH_BASE + 3 * choice_idx(c2) + choice_idx(c1));
    endfunction

    function automatic logic is_draw_state(input state_t s);
        return (s == ST_TITLE) || (s == ST_PROMPT) || (s == ST_SHOW) || (s == ST_FINAL);
    endfunction

endpackage

// File: rtl/button_edge.sv
// Button conditioner: optional counter debounce (DEBOUNCE_EN) followed by a
// one-cycle rising-edge pulse on the conditioned level.
module button_edge #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic press
);

    if (DB_CYCLES < 1) begin : g_bad_db_cycles
        $error("button_edge: DB_CYCLES must be at least 1");
    end

    logic level;
    logic last;

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic [CW-1:0] stable_cnt;

    // The filtered level only follows raw after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (raw == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DB_CYCLES - 1)) begin
            level      <= raw;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
`else
    assign level = raw;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last <= 1'b0;
        else
            last <= level;
    end

    assign press = level & ~last;

endmodule

// File: rtl/round_sequencer.sv
// Match sequencer: latches choices, scores rounds, detects the match winner and
// drives the drawing datapath over draw_req/draw_done. Define DEBOUNCE_EN to filter buttons.
module round_sequencer
    import game_pkg::*;
#(
    parameter int WIN_SCORE = 3,
    parameter int DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       user_cont,
    input  logic       user_choose,
    input  logic       user_reset_game,
    input  logic [2:0] p1_choice,
    input  logic [2:0] p2_choice,
    input  logic       draw_done,
    output logic       draw_req,
    output logic [6:0] screen_sel,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] round_result,
    output logic [1:0] match_winner
);

    if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win_score
        $error("round_sequencer: WIN_SCORE must be in 1..15");
    end

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    logic cont_press, choose_press, ng_press;

    button_edge #(.DB_CYCLES(DB_CYCLES)) u_cont_edge (
        .clk(clk), .resetn(resetn), .raw(user_cont), .press(cont_press)
    );
    button_edge #(.DB_CYCLES(DB_CYCLES)) u_choose_edge (
        .clk(clk), .resetn(resetn), .raw(user_choose), .press(choose_press)
    );
    button_edge #(.DB_CYCLES(DB_CYCLES)) u_ng_edge (
        .clk(clk), .resetn(resetn), .raw(user_reset_game), .press(ng_press)
    );

    state_t     state_q, state_d;
    logic       draw_req_q, draw_req_d;
    logic [6:0] screen_q, screen_d;
    logic [3:0] score1_q, score1_d, score2_q, score2_d;
    result_t    rr_q, rr_d, mw_q, mw_d;
    choice_t    c1_q, c1_d, c2_q, c2_d;
    logic       ng_pending_q, ng_pending_d;
    logic       draw_finished;

    // NOTE: every next-state value gets its default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        draw_req_d   = draw_req_q;
        screen_d     = screen_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        rr_d         = rr_q;
        mw_d         = mw_q;
        c1_d         = c1_q;
        c2_d         = c2_q;
        ng_pending_d = ng_pending_q;
        draw_finished = draw_req_q && draw_done;

        // A new game never interrupts a frame in flight; it waits for draw_done.
        if (ng_press && draw_req_q)
            ng_pending_d = 1'b1;

        if ((ng_press || ng_pending_q) && !draw_req_q) begin
            score1_d     = '0;
            score2_d     = '0;
            rr_d         = RES_NONE;
            mw_d         = RES_NONE;
            ng_pending_d = 1'b0;
            state_d      = ST_TITLE;
        end else begin
            case (state_q)
                ST_TITLE:       if (draw_finished) state_d = ST_WAIT_START;
                ST_WAIT_START:  if (cont_press) state_d = ST_PROMPT;
                ST_PROMPT:      if (draw_finished) state_d = ST_WAIT_CHOICE;
                ST_WAIT_CHOICE: if (choose_press) begin
                    c1_d    = decode_choice(p1_choice);
                    c2_d    = decode_choice(p2_choice);
                    state_d = ST_RESOLVE;
                end
                ST_RESOLVE: begin
                    rr_d = judge(c1_q, c2_q);
                    if (rr_d == RES_P1 && score1_q < WIN) score1_d = score1_q + 4'd1;
                    if (rr_d == RES_P2 && score2_q < WIN) score2_d = score2_q + 4'd1;
                    state_d = ST_SHOW;
                end
                ST_SHOW:        if (draw_finished) state_d = ST_CHECK;
                ST_CHECK: begin
                    if (score1_q == WIN) begin
                        mw_d    = RES_P1;
                        state_d = ST_FINAL;
                    end else if (score2_q == WIN) begin
                        mw_d    = RES_P2;
                        state_d = ST_FINAL;
                    end else begin
                        state_d = ST_WAIT_CONT;
                    end
                end
                ST_WAIT_CONT: if (cont_press) begin
                    rr_d    = RES_NONE;
                    state_d = ST_PROMPT;
                end
                ST_FINAL:       if (draw_finished) state_d = ST_OVER;
                ST_OVER:        ;
                default:        state_d = ST_TITLE;
            endcase
        end

        // screen_sel only moves when a request is raised, so it is stable for the whole frame.
        if (draw_req_q) begin
            if (draw_done)
                draw_req_d = 1'b0;
        end else if (is_draw_state(state_d)) begin
            draw_req_d = 1'b1;
            case (state_d)
                ST_TITLE:  screen_d = SCR_TITLE;
                ST_PROMPT: screen_d = SCR_PROMPT;
                ST_SHOW:   screen_d = matchup_screen(c1_q, c2_q);
                default:   screen_d = (mw_d == RES_P1) ? SCR_P1WIN : SCR_P2WIN;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_TITLE;
            draw_req_q   <= 1'b0;
            screen_q     <= SCR_TITLE;
            score1_q     <= '0;
            score2_q     <= '0;
            rr_q         <= RES_NONE;
            mw_q         <= RES_NONE;
            // NOTE: the latched choices are reset too; they are two small registers, not a memory array.
            c1_q         <= CAT;
            c2_q         <= CAT;
            ng_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            draw_req_q   <= draw_req_d;
            screen_q     <= screen_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            rr_q         <= rr_d;
            mw_q         <= mw_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            ng_pending_q <= ng_pending_d;
        end
    end

    assign draw_req     = draw_req_q;
    assign screen_sel   = screen_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign round_result = rr_q;
    assign match_winner = mw_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: a scoreboard queue of expected screens
// is filled as stimulus is driven and drained as the bench serves each draw request.
module tb_round_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       user_cont, user_choose, user_reset_game;
    logic [2:0] p1_choice, p2_choice;
    logic       draw_done;
    logic       draw_req;
    logic [6:0] screen_sel;
    logic [3:0] score1, score2;
    logic [1:0] round_result, match_winner;

    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] exp_q[$];

    round_sequencer dut (
        .clk(clk), .resetn(resetn),
        .user_cont(user_cont), .user_choose(user_choose), .user_reset_game(user_reset_game),
        .p1_choice(p1_choice), .p2_choice(p2_choice), .draw_done(draw_done),
        .draw_req(draw_req), .screen_sel(screen_sel),
        .score1(score1), .score2(score2),
        .round_result(round_result), .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Datapath stand-in: wait for a request, check it against the scoreboard,
    // answer draw_done five cycles later, then confirm draw_req drops.
    task automatic serve_draw(input string tag, input bit ng_mid);
        int         waited = 0;
        logic [6:0] exp_sel, sel0;
        bit         unstable = 0;
        while (draw_req !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (draw_req !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_req_timeout: draw_req=%b after %0d cycles, required 1", tag, draw_req, waited);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s_unexpected_draw: screen_sel=%0d, required no draw", tag, screen_sel);
        end else begin
            exp_sel = exp_q.pop_front();
            if (screen_sel !== exp_sel) begin
                n_bad++;
                $display("FAIL %s_screen: screen_sel=%0d, required %0d", tag, screen_sel, exp_sel);
            end
        end
        sel0 = screen_sel;
        for (int i = 0; i < 4; i++) begin
            if (ng_mid && i == 1) user_reset_game = 1'b1;
            if (ng_mid && i == 2) user_reset_game = 1'b0;
            @(negedge clk);
            if (screen_sel !== sel0 || draw_req !== 1'b1) unstable = 1;
        end
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        n_cmp++;
        if (unstable) begin
            n_bad++;
            $display("FAIL %s_hold: screen_sel/draw_req changed mid-frame, required stable %0d", tag, sel0);
        end
        n_cmp++;
        if (draw_req !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_drop: draw_req=%b after done, required 0", tag, draw_req);
        end
    endtask

    task automatic press_cont();
        @(negedge clk); user_cont = 1'b1;
        @(negedge clk); user_cont = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        user_cont = 0; user_choose = 0; user_reset_game = 0;
        p1_choice = 3'b001; p2_choice = 3'b001; draw_done = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (draw_req !== 1'b0 || screen_sel !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_draw: draw_req=%b screen_sel=%0d, required 0/0", draw_req, screen_sel);
        end
        n_cmp++;
        if (score1 !== 4'd0 || score2 !== 4'd0 || round_result !== 2'b00 || match_winner !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_scores: s1=%0d s2=%0d rr=%b mw=%b, required all 0",
                     score1, score2, round_result, match_winner);
        end
        resetn = 1'b1;
    endtask

    task automatic test_title_prompt();
        exp_q.push_back(7'd0);
        serve_draw("title", 0);
        // draw_done with no request outstanding must be ignored.
        @(negedge clk); draw_done = 1'b1;
        @(negedge clk); draw_done = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (draw_req !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_done: draw_req=%b, required 0", draw_req);
        end
        exp_q.push_back(7'd1);
        press_cont();
        serve_draw("prompt", 0);
    endtask

    task automatic test_round(input string tag, input logic [2:0] p1, input logic [2:0] p2,
                              input logic [1:0] exp_rr, input logic [3:0] exp_s1,
                              input logic [3:0] exp_s2, input logic [6:0] exp_sel,
                              input bit hold, input bit ng_mid);
        @(negedge clk);
        p1_choice = p1; p2_choice = p2; user_choose = 1'b1;
        exp_q.push_back(exp_sel);
        @(negedge clk);
        if (!hold) user_choose = 1'b0;
        n_cmp++;
        if (draw_req !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_resolve_req: draw_req=%b in RESOLVE cycle, required 0", tag, draw_req);
        end
        @(negedge clk);
        n_cmp++;
        if (draw_req !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_latency: draw_req=%b two edges after Choose, required 1", tag, draw_req);
        end
        n_cmp++;
        if (round_result !== exp_rr || score1 !== exp_s1 || score2 !== exp_s2) begin
            n_bad++;
            $display("FAIL %s_result: rr=%b s1=%0d s2=%0d, required rr=%b s1=%0d s2=%0d",
                     tag, round_result, score1, score2, exp_rr, exp_s1, exp_s2);
        end
        serve_draw({tag, "_show"}, ng_mid);
    endtask

    task automatic next_round();
        exp_q.push_back(7'd1);
        press_cont();
        serve_draw("reprompt", 0);
        n_cmp++;
        if (round_result !== 2'b00) begin
            n_bad++;
            $display("FAIL cont_clear: rr=%b after Continue, required 00", round_result);
        end
    endtask

    task automatic test_rounds();
        test_round("dog_cat", 3'b010, 3'b001, 2'b01, 4'd1, 4'd0, 7'd3, 0, 0);
        next_round();
        test_round("tie", 3'b100, 3'b100, 2'b00, 4'd1, 4'd0, 7'd10, 0, 0);
        next_round();
    endtask

    task automatic test_choose_held();
        test_round("held", 3'b011, 3'b100, 2'b01, 4'd2, 4'd0, 7'd8, 1, 0);
        next_round();
        repeat (30) @(negedge clk);
        n_cmp++;
        if (draw_req !== 1'b0 || score1 !== 4'd2 || round_result !== 2'b00) begin
            n_bad++;
            $display("FAIL held_once: draw_req=%b s1=%0d rr=%b, required 0/2/00",
                     draw_req, score1, round_result);
        end
        user_choose = 1'b0;
    endtask

    task automatic test_newgame_mid_draw();
        test_round("ng", 3'b001, 3'b010, 2'b10, 4'd2, 4'd1, 7'd5, 0, 1);
        n_cmp++;
        if (score1 !== 4'd2 || score2 !== 4'd1) begin
            n_bad++;
            $display("FAIL ng_early: s1=%0d s2=%0d on done cycle, required 2/1", score1, score2);
        end
        exp_q.push_back(7'd0);
        serve_draw("ng_title", 0);
        n_cmp++;
        if (score1 !== 4'd0 || score2 !== 4'd0 || round_result !== 2'b00) begin
            n_bad++;
            $display("FAIL ng_clear: s1=%0d s2=%0d rr=%b, required 0/0/00", score1, score2, round_result);
        end
        exp_q.push_back(7'd1);
        press_cont();
        serve_draw("ng_prompt", 0);
    endtask

    task automatic test_match_win();
        test_round("p2a", 3'b001, 3'b010, 2'b10, 4'd0, 4'd1, 7'd5, 0, 0);
        next_round();
        test_round("p2b", 3'b001, 3'b010, 2'b10, 4'd0, 4'd2, 7'd5, 0, 0);
        next_round();
        test_round("p2c", 3'b001, 3'b010, 2'b10, 4'd0, 4'd3, 7'd5, 0, 0);
        exp_q.push_back(7'd12);
        serve_draw("final", 0);
        n_cmp++;
        if (match_winner !== 2'b10 || score2 !== 4'd3) begin
            n_bad++;
            $display("FAIL match_winner: mw=%b s2=%0d, required 10/3", match_winner, score2);
        end
        press_cont();
        @(negedge clk);
        user_choose = 1'b1;
        @(negedge clk);
        user_choose = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (draw_req !== 1'b0 || score2 !== 4'd3 || match_winner !== 2'b10 || round_result !== 2'b10) begin
            n_bad++;
            $display("FAIL over_ignore: draw_req=%b s2=%0d mw=%b rr=%b, required 0/3/10/10",
                     draw_req, score2, match_winner, round_result);
        end
    endtask

    task automatic test_newgame_idle();
        exp_q.push_back(7'd0);
        @(negedge clk); user_reset_game = 1'b1;
        @(negedge clk); user_reset_game = 1'b0;
        n_cmp++;
        if (draw_req !== 1'b1 || screen_sel !== 7'd0 || score2 !== 4'd0 || match_winner !== 2'b00) begin
            n_bad++;
            $display("FAIL ng_idle: draw_req=%b sel=%0d s2=%0d mw=%b, required 1/0/0/00",
                     draw_req, screen_sel, score2, match_winner);
        end
        serve_draw("ng_idle_title", 0);
    endtask

    initial begin
        test_reset();
        test_title_prompt();
        test_rounds();
        test_choose_held();
        test_newgame_mid_draw();
        test_match_win();
        test_newgame_idle();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_left: %0d screens never drawn, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
